prefetch_buffer: RTL and testbench

- Sits between the instruction-memory port and the IF stage.
- Issues sequential word fetches over a req/gnt/rvalid handshake and buffers returned instructions in a small FIFO.
- Delivers each instruction and its PC to the IF stage with a valid/ready handshake.
- On a redirect (branch/jump), flushes buffered and in-flight instructions and restarts fetch at the target.

---
 rtl/prefetch_buffer.sv | 176 +++++++++++++++++
 tb/tb_prefetch_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches, buffers responses
// in a small FIFO and hands {instruction, PC} to the IF stage; redirects flush stale data.
module prefetch_buffer #(
  parameter int                    WORD_WIDTH      = 32,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic [WORD_WIDTH-1:0] addr_o,
  input  logic                  ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  // Wide enough for MAX_OUTSTANDING plus one held-but-ungranted request.
  localparam int OW = $clog2(MAX_OUTSTANDING + 2);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic                  req_reg, req_next;
  logic [WORD_WIDTH-1:0] fetch_addr_reg, fetch_addr_next;
  logic [WORD_WIDTH-1:0] target_reg, target_next;
  logic                  redirect_reg, redirect_next;
  logic [WORD_WIDTH-1:0] ret_addr_reg, ret_addr_next;
  logic [OW-1:0]         outstanding_reg, outstanding_next;
  logic [OW-1:0]         drop_reg, drop_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [SW-1:0]         occupancy_next;

  logic [WORD_WIDTH-1:0] data_mem [DEPTH];
  logic [WORD_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DEPTH-1:0]      wr_sel;

  logic                  gnt_acc;
  logic                  hold;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] branch_target;

  assign branch_target = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
  assign gnt_acc       = req_reg & instr_gnt_i;
  assign hold          = req_reg & ~instr_gnt_i;
  assign pop           = valid_o & ready_i;
  assign push          = instr_rvalid_i & ~branch_i & (drop_reg == '0);

  assign instr_req_o  = req_reg;
  assign instr_addr_o = fetch_addr_reg;
  assign valid_o      = (count_reg != '0) & ~branch_i;
  assign rdata_o      = data_mem[rd_ptr_reg];
  assign addr_o       = pc_mem[rd_ptr_reg];

  // Counters, FIFO bookkeeping and request decision.
  always_comb begin
    outstanding_next = outstanding_reg + OW'(gnt_acc) - OW'(instr_rvalid_i);

    // Everything in flight after a branch is stale, including a held request
    // that has not been granted yet; the count replaces any previous one.
    drop_next = drop_reg;
    if (branch_i) begin
      drop_next = outstanding_next + OW'(hold);
    end else if (instr_rvalid_i && (drop_reg != '0)) begin
      drop_next = drop_reg - OW'(1);
    end

    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (branch_i) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      count_next  = count_reg + CW'(push) - CW'(pop);
      wr_ptr_next = wr_ptr_reg + PW'(push);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
    end

    occupancy_next = SW'(count_next) + SW'(outstanding_next);
    req_next = hold |
               (fetch_en_i &&
                (outstanding_next < OW'(MAX_OUTSTANDING)) &&
                (occupancy_next < SW'(DEPTH)));
  end

  // Fetch address: a held request keeps its address; the redirect target is
  // applied at the grant of that request instead of the usual increment.
  always_comb begin
    fetch_addr_next = fetch_addr_reg;
    redirect_next   = redirect_reg;
    target_next     = branch_i ? branch_target : target_reg;
    if (gnt_acc) begin
      redirect_next = 1'b0;
      if (branch_i) begin
        fetch_addr_next = branch_target;
      end else if (redirect_reg) begin
        fetch_addr_next = target_reg;
      end else begin
        fetch_addr_next = fetch_addr_reg + WORD_WIDTH'(4);
      end
    end else if (branch_i) begin
      if (req_reg) begin
        redirect_next = 1'b1;
      end else begin
        fetch_addr_next = branch_target;
      end
    end

    ret_addr_next = ret_addr_reg;
    if (branch_i) begin
      ret_addr_next = branch_target;
    end else if (push) begin
      ret_addr_next = ret_addr_reg + WORD_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg         <= 1'b0;
      fetch_addr_reg  <= BOOT_ADDR;
      target_reg      <= BOOT_ADDR;
      redirect_reg    <= 1'b0;
      ret_addr_reg    <= BOOT_ADDR;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      req_reg         <= req_next;
      fetch_addr_reg  <= fetch_addr_next;
      target_reg      <= target_next;
      redirect_reg    <= redirect_next;
      ret_addr_reg    <= ret_addr_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push & (wr_ptr_reg == PW'(gi));
  end

  // Storage is reset so the head reads as {0, BOOT_ADDR} out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= BOOT_ADDR;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          data_mem[i] <= instr_rdata_i;
          pc_mem[i]   <= ret_addr_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: memory model with optional grant/response
// stalls, pop recorder, and one task per scenario with hand-computed expectations.
module tb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        ready_i = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic        gnt_hold = 1'b0;
  logic        rsp_en = 1'b1;
  logic [31:0] pend_q[$];
  int          max_pend = 0;
  int          cyc = 0;
  logic [31:0] pop_addr[$];
  logic [31:0] pop_data[$];
  int          pop_cyc[$];

  prefetch_buffer #(
    .WORD_WIDTH(32), .DEPTH(4), .MAX_OUTSTANDING(2), .BOOT_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory: grant in the request cycle unless held, respond one cycle later unless stalled.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pend_q.delete();
      instr_gnt_i = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i = '0;
    end else begin
      if (rsp_en && pend_q.size() > 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i = mem_word(pend_q.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
      end
      if (instr_req_o && !gnt_hold) begin
        instr_gnt_i = 1'b1;
        pend_q.push_back(instr_addr_o);
      end else begin
        instr_gnt_i = 1'b0;
      end
      if (pend_q.size() > max_pend) max_pend = pend_q.size();
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && valid_o && ready_i) begin
      pop_addr.push_back(addr_o);
      pop_data.push_back(rdata_o);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_en_i = 1'b0; ready_i = 1'b0; branch_i = 1'b0;
    branch_addr_i = '0; gnt_hold = 1'b0; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pop_addr.delete(); pop_data.delete(); pop_cyc.delete();
    max_pend = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", instr_req_o); end
    n_cmp++; if (instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr_addr: got %h want 00000000", instr_addr_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata_o); end
    n_cmp++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", addr_o); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    apply_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %0b want 0", valid_o); end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b1 || addr_o !== 32'h0) begin n_fail++; $display("FAIL stream_first: got valid=%0b addr=%h want valid=1 addr=00000000", valid_o, addr_o); end
    repeat (9) @(negedge clk);
    n_cmp++;
    if (pop_addr.size() < 8) begin
      n_fail++; $display("FAIL stream_count: got %0d pops want >=8", pop_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (pop_addr[i] !== 32'(4 * i) || pop_data[i] !== (32'hDEAD_0000 | 32'(4 * i))) begin
          n_fail++; $display("FAIL stream_pop%0d: got addr=%h data=%h want addr=%h data=%h", i, pop_addr[i], pop_data[i], 32'(4 * i), 32'hDEAD_0000 | 32'(4 * i));
        end
      end
      n_cmp++; if (pop_cyc[7] - pop_cyc[0] != 7) begin n_fail++; $display("FAIL stream_gapless: got span %0d want 7", pop_cyc[7] - pop_cyc[0]); end
    end
    n_cmp++; if (max_pend > 2) begin n_fail++; $display("FAIL stream_outstanding: got %0d want <=2", max_pend); end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_en_i = 1'b1; ready_i = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %0b want 0", instr_req_o); end
    n_cmp++; if (valid_o !== 1'b1 || addr_o !== 32'h0 || rdata_o !== 32'hDEAD_0000) begin n_fail++; $display("FAIL bp_head: got valid=%0b addr=%h data=%h want 1/00000000/dead0000", valid_o, addr_o, rdata_o); end
    n_cmp++; if (pend_q.size() != 0) begin n_fail++; $display("FAIL bp_inflight: got %0d want 0", pend_q.size()); end
    ready_i = 1'b1; fetch_en_i = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got valid=%0b want 0", valid_o); end
    n_cmp++;
    if (pop_addr.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d pops want 4", pop_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (pop_addr[i] !== 32'(4 * i) || pop_data[i] !== (32'hDEAD_0000 | 32'(4 * i))) begin
          n_fail++; $display("FAIL bp_pop%0d: got addr=%h data=%h want addr=%h", i, pop_addr[i], pop_data[i], 32'(4 * i));
        end
      end
      n_cmp++; if (pop_cyc[3] - pop_cyc[0] != 3) begin n_fail++; $display("FAIL bp_gapless: got span %0d want 3", pop_cyc[3] - pop_cyc[0]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_branch_outstanding();
    apply_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1; rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pend_q.size() != 2 || instr_req_o !== 1'b0) begin n_fail++; $display("FAIL bo_limit: got inflight=%0d req=%0b want 2/0", pend_q.size(), instr_req_o); end
    branch_i = 1'b1; branch_addr_i = 32'h0000_0103;
    @(negedge clk);
    branch_i = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bo_drop1: got valid=%0b want 0", valid_o); end
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin n_fail++; $display("FAIL bo_newreq: got req=%0b addr=%h want 1/00000100", instr_req_o, instr_addr_o); end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bo_drop2: got valid=%0b want 0", valid_o); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pop_addr.size() < 2) begin
      n_fail++; $display("FAIL bo_count: got %0d pops want >=2", pop_addr.size());
    end else begin
      n_cmp++; if (pop_addr[0] !== 32'h100 || pop_data[0] !== 32'hDEAD_0100) begin n_fail++; $display("FAIL bo_pop0: got addr=%h data=%h want 00000100/dead0100", pop_addr[0], pop_data[0]); end
      n_cmp++; if (pop_addr[1] !== 32'h104 || pop_data[1] !== 32'hDEAD_0104) begin n_fail++; $display("FAIL bo_pop1: got addr=%h data=%h want 00000104/dead0104", pop_addr[1], pop_data[1]); end
    end
    $display("test_branch_outstanding done");
  endtask

  task automatic test_branch_pending();
    apply_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1; gnt_hold = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL bp_req_raise: got req=%0b addr=%h want 1/00000000", instr_req_o, instr_addr_o); end
    @(negedge clk);
    branch_i = 1'b1; branch_addr_i = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      branch_i = 1'b0;
      n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL pend_stable%0d: got req=%0b addr=%h want 1/00000000", i, instr_req_o, instr_addr_o); end
    end
    gnt_hold = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin n_fail++; $display("FAIL pend_target: got req=%0b addr=%h want 1/00000100", instr_req_o, instr_addr_o); end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL pend_drop: got valid=%0b want 0", valid_o); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pop_addr.size() < 2) begin
      n_fail++; $display("FAIL pend_count: got %0d pops want >=2", pop_addr.size());
    end else begin
      n_cmp++; if (pop_addr[0] !== 32'h100 || pop_data[0] !== 32'hDEAD_0100) begin n_fail++; $display("FAIL pend_pop0: got addr=%h data=%h want 00000100/dead0100", pop_addr[0], pop_data[0]); end
      n_cmp++; if (pop_addr[1] !== 32'h104 || pop_data[1] !== 32'hDEAD_0104) begin n_fail++; $display("FAIL pend_pop1: got addr=%h data=%h want 00000104/dead0104", pop_addr[1], pop_data[1]); end
    end
    $display("test_branch_pending done");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    branch_i = 1'b1; branch_addr_i = 32'h0000_0180;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_flush: got valid=%0b want 0", valid_o); end
    branch_addr_i = 32'h0000_0200;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got valid=%0b want 0", valid_o); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (pop_addr.size() < 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d pops want >=2", pop_addr.size());
    end else begin
      n_cmp++; if (pop_addr[0] !== 32'h200 || pop_data[0] !== 32'hDEAD_0200) begin n_fail++; $display("FAIL b2b_pop0: got addr=%h data=%h want 00000200/dead0200", pop_addr[0], pop_data[0]); end
      n_cmp++; if (pop_addr[1] !== 32'h204 || pop_data[1] !== 32'hDEAD_0204) begin n_fail++; $display("FAIL b2b_pop1: got addr=%h data=%h want 00000204/dead0204", pop_addr[1], pop_data[1]); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1;
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_i = 1'b0;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got req=%0b addr=%h want 1/fffffffc", instr_req_o, instr_addr_o); end
    @(negedge clk);
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_req1: got req=%0b addr=%h want 1/00000000", instr_req_o, instr_addr_o); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pop_addr.size() < 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d pops want >=2", pop_addr.size());
    end else begin
      n_cmp++; if (pop_addr[0] !== 32'hFFFF_FFFC || pop_data[0] !== 32'h2152_FFFC) begin n_fail++; $display("FAIL wrap_pop0: got addr=%h data=%h want fffffffc/2152fffc", pop_addr[0], pop_data[0]); end
      n_cmp++; if (pop_addr[1] !== 32'h0 || pop_data[1] !== 32'hDEAD_0000) begin n_fail++; $display("FAIL wrap_pop1: got addr=%h data=%h want 00000000/dead0000", pop_addr[1], pop_data[1]); end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL midrst_req: got req=%0b addr=%h want 0/00000000", instr_req_o, instr_addr_o); end
    n_cmp++; if (valid_o !== 1'b0 || addr_o !== 32'h0 || rdata_o !== 32'h0) begin n_fail++; $display("FAIL midrst_out: got valid=%0b addr=%h data=%h want 0/0/0", valid_o, addr_o, rdata_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (valid_o !== 1'b1 || addr_o !== 32'h0 || rdata_o !== 32'hDEAD_0000) begin n_fail++; $display("FAIL midrst_restart: got valid=%0b addr=%h data=%h want 1/00000000/dead0000", valid_o, addr_o, rdata_o); end
    $display("test_wrap_and_reset done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_outstanding();
    test_branch_pending();
    test_back_to_back();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
